// File: rtl/fibonacci_gen.sv
// fibonacci_gen: iterative Fibonacci / Lucas sequence engine with saturation.
// Computes F(n) (mode=0, seeds 0,1) or L(n) (mode=1, seeds 2,1) one term per
// clock. Results that exceed F_W bits saturate to all-ones and raise o_ovf.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for i_start; o_ready=1
// S_OP   | iterating; one term per cycle until the index counter hits 0
// S_DONE | one-cycle result strobe (o_done_tick); returns to S_IDLE
module fibonacci_gen #(
  parameter int N_W = 8,
  parameter int F_W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic           i_mode,
  input  logic [N_W-1:0] i_n,
  output logic           o_ready,
  output logic           o_busy,
  output logic           o_done_tick,
  output logic [F_W-1:0] o_f,
  output logic           o_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [N_W-1:0] r_cnt;
  logic [F_W-1:0] r_t0;
  logic [F_W-1:0] r_t1;
  // Saturation flags travel alongside t0/t1 so that an overflowed F(n+1)
  // never taints a valid F(n).
  logic           r_s0;
  logic           r_s1;
  logic [F_W-1:0] r_f;
  logic           r_ovf;

  logic [F_W:0]   w_sum;
  logic           w_sat;
  logic           w_cnt_zero;

  assign w_sum      = {1'b0, r_t0} + {1'b0, r_t1};
  assign w_sat      = r_s0 | r_s1 | w_sum[F_W];
  assign w_cnt_zero = (r_cnt == '0);

  assign o_f   = r_f;
  assign o_ovf = r_ovf;

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and status outputs; abort outranks completion in S_OP.
  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_busy       = 1'b0;
    o_done_tick  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_state_next = S_OP;
      end
      S_OP: begin
        o_busy = 1'b1;
        if (i_abort)         w_state_next = S_IDLE;
        else if (w_cnt_zero) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done_tick  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: seed on accept, iterate in OP, publish result on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_t0  <= '0;
      r_t1  <= '0;
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
      r_f   <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt <= i_n;
            r_t0  <= i_mode ? F_W'(2) : '0;
            r_t1  <= F_W'(1);
            r_s0  <= 1'b0;
            r_s1  <= 1'b0;
          end
        end
        S_OP: begin
          if (!i_abort) begin
            if (w_cnt_zero) begin
              r_f   <= r_t0;
              r_ovf <= r_s0;
            end else begin
              r_t1  <= w_sat ? '1 : w_sum[F_W-1:0];
              r_s1  <= w_sat;
              r_t0  <= r_t1;
              r_s0  <= r_s1;
              r_cnt <= r_cnt - N_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_gen.sv
// Self-checking bench for fibonacci_gen: default 8/32 instance plus a 4/8
// instance, table-driven runs and hand-written corner sequences.
module tb_fibonacci_gen;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, abort_a, mode_a;
  logic [7:0]  n_a;
  logic        ready_a, busy_a, done_a, ovf_a;
  logic [31:0] f_a;

  logic        start_b, abort_b, mode_b;
  logic [3:0]  n_b;
  logic        ready_b, busy_b, done_b, ovf_b;
  logic [7:0]  f_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fibonacci_gen #(.N_W(8), .F_W(32)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_abort(abort_a),
    .i_mode(mode_a), .i_n(n_a), .o_ready(ready_a), .o_busy(busy_a),
    .o_done_tick(done_a), .o_f(f_a), .o_ovf(ovf_a)
  );

  fibonacci_gen #(.N_W(4), .F_W(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(abort_b),
    .i_mode(mode_b), .i_n(n_b), .o_ready(ready_b), .o_busy(busy_b),
    .o_done_tick(done_b), .o_f(f_b), .o_ovf(ovf_b)
  );

  // Output view of whichever instance is under test.
  logic        sel = 1'b0;
  logic        w_ready, w_busy, w_done, w_ovf;
  logic [31:0] w_f;
  assign w_ready = sel ? ready_b : ready_a;
  assign w_busy  = sel ? busy_b  : busy_a;
  assign w_done  = sel ? done_b  : done_a;
  assign w_ovf   = sel ? ovf_b   : ovf_a;
  assign w_f     = sel ? {24'd0, f_b} : f_a;

  typedef struct {
    bit          s;
    bit          mode;
    int          n;
    logic [31:0] exp_f;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  task automatic drive_start(input bit s, input bit m, input int nv, input bit v);
    if (s) begin start_b = v; mode_b = m; n_b = nv[3:0]; end
    else   begin start_a = v; mode_a = m; n_a = nv[7:0]; end
  endtask

  // Full operation: accept, measure latency, check result and return to idle.
  task automatic run_op(input bit s, input bit m, input int nv,
                        input logic [31:0] ef, input bit eo, input string nm);
    int lat;
    sel = s;
    @(negedge clk);
    chk({nm, "_ready_pre"}, w_ready, 1);
    drive_start(s, m, nv, 1'b1);
    @(negedge clk);
    drive_start(s, m, nv, 1'b0);
    lat = 1;
    while (!w_done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, nv + 2);
    chk({nm, "_f"}, w_f, ef);
    chk({nm, "_ovf"}, w_ovf, eo);
    @(negedge clk);
    chk({nm, "_done_single"}, w_done, 0);
    chk({nm, "_ready_post"}, w_ready, 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start_a = 0; abort_a = 0; mode_a = 0; n_a = '0;
    start_b = 0; abort_b = 0; mode_b = 0; n_b = '0;

    vecs.push_back('{0, 0, 10,  32'd55,         0});
    vecs.push_back('{0, 0, 0,   32'd0,          0});
    vecs.push_back('{0, 1, 0,   32'd2,          0});
    vecs.push_back('{0, 1, 10,  32'd123,        0});
    vecs.push_back('{0, 0, 21,  32'd10946,      0});
    vecs.push_back('{0, 0, 47,  32'd2971215073, 0});
    vecs.push_back('{0, 0, 48,  32'hFFFFFFFF,   1});
    vecs.push_back('{0, 0, 255, 32'hFFFFFFFF,   1});
    vecs.push_back('{0, 1, 46,  32'd4106118243, 0});
    vecs.push_back('{0, 1, 47,  32'hFFFFFFFF,   1});
    vecs.push_back('{1, 0, 13,  32'd233,        0});
    vecs.push_back('{1, 0, 14,  32'd255,        1});
    vecs.push_back('{1, 0, 15,  32'd255,        1});

    repeat (10) @(negedge clk);
    chk("rst_ready", ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_f", f_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_ready_b", ready_b, 1);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].s, vecs[i].mode, vecs[i].n, vecs[i].exp_f, vecs[i].exp_ovf,
             $sformatf("vec%0d", i));

    // Start held for 10 cycles, then toggled with new n/mode during OP.
    sel = 0;
    @(negedge clk);
    start_a = 1; mode_a = 0; n_a = 8'd32;
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 9) start_a = 0;
      if (c >= 12 && c < 20) begin start_a = ~start_a; n_a = 8'd3; mode_a = 1; end
      if (c == 20) begin start_a = 0; mode_a = 0; end
      if (done_a) cnt++;
    end
    chk("hold_done_count", cnt, 1);
    chk("hold_f", f_a, 32'd2178309);
    chk("hold_ovf", ovf_a, 0);

    // Abort on the 5th OP cycle after a completed n=10 run.
    run_op(0, 0, 10, 32'd55, 0, "pre_abort");
    @(negedge clk);
    start_a = 1; n_a = 8'd33; mode_a = 0;
    @(negedge clk);
    start_a = 0;
    repeat (4) @(negedge clk);
    chk("abort_busy", busy_a, 1);
    abort_a = 1;
    @(negedge clk);
    abort_a = 0;
    chk("abort_ready", ready_a, 1);
    chk("abort_busy_off", busy_a, 0);
    chk("abort_f", f_a, 32'd55);
    chk("abort_ovf", ovf_a, 0);
    cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_op(0, 0, 33, 32'd3524578, 0, "post_abort");

    // Reset pulse in the middle of an n=37 run.
    @(negedge clk);
    start_a = 1; n_a = 8'd37;
    @(negedge clk);
    start_a = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_ready", ready_a, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_f", f_a, 0);
    chk("midrst_ovf", ovf_a, 0);
    cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run_op(0, 0, 37, 32'd24157817, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_gen.md
Name: fibonacci_gen

Overview:
Parametrised iterative sequence engine; successor to the fixed 8-bit Fibonacci core driven from switches/start button. Computes F(n) (Fibonacci) or L(n) (Lucas) for a run-time index with configurable index and result widths. Adds saturation with an overflow flag and an abort input. Sits between the input debouncer/switch logic and the BCD/seven-segment display path.

Parameters:
N_W, 8, width of index input n (n range 0..2^N_W-1)
F_W, 32, width of result f (must be >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only when ready=1
abort  in  1  cancel running operation; ignored unless busy
mode  in  1  0 = Fibonacci (seeds 0,1), 1 = Lucas (seeds 2,1); sampled with start
n  in  N_W  sequence index; sampled with start
ready  out  1  high in IDLE only
busy  out  1  high in OP only
done_tick  out  1  one-cycle pulse, result valid
f  out  F_W  result; holds last completed value
ovf  out  1  result saturated; holds with f

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-operation): state IDLE, ready=1, busy=0, done_tick=0, f=0, ovf=0, internal regs cleared. No done_tick for an interrupted operation.
- FSM states: IDLE, OP, DONE.
- IDLE: ready=1. On start=1: latch cnt<=n; t0<=mode?2:0; t1<=1; s0<=0; s1<=0 (saturation flags); go OP. start=0: stay.
- OP: busy=1; start ignored.
  - abort=1: go IDLE; f, ovf unchanged; no done_tick. Abort has priority over iteration/completion.
  - else cnt==0: f<=t0, ovf<=s0; go DONE.
  - else: sum=t0+t1 computed in F_W+1 bits; sat=s0|s1|sum[F_W]; t1<=sat ? all-ones : sum[F_W-1:0]; s1<=sat; t0<=t1; s0<=s1; cnt<=cnt-1.
- DONE: done_tick=1 for exactly this cycle; f/ovf valid from this cycle; go IDLE unconditionally (start here ignored).
- Latency: start accepted at edge k -> done_tick high in cycle k+n+2 (n iterations + 1 completion + DONE). n=0 -> done_tick 2 cycles after acceptance.
- Back-to-back: earliest next acceptance is first IDLE cycle after DONE.
- Saturation: ovf=1 iff true result exceeds 2^F_W-1; then f=all-ones. Overflow of t1 alone (i.e. F(n+1)) must not set ovf for F(n).
- f/ovf change only at completion or reset; stable through next operation's OP.
- n=2^N_W-1 must terminate correctly (no counter wrap).
- mode, n changes while busy have no effect.

Test Plan:
- Reset 10 cycles, mode=0, n=10 (0x0a), pulse start 1 cycle -> done_tick exactly 12 cycles after acceptance edge, f=55, ovf=0, ready returns next cycle.
- mode=0 n=0 -> f=0; mode=1 n=0 -> f=2; mode=1 n=10 -> f=123; mode=0 n=21 (0x15) -> f=10946; each done_tick single cycle.
- Defaults, mode=0: n=47 -> f=2971215073, ovf=0; n=48 -> f=0xFFFFFFFF, ovf=1; n=255 -> f=0xFFFFFFFF, ovf=1, done_tick at k+257. mode=1: n=46 -> 4106118243 ovf=0; n=47 -> ovf=1.
- Start held high 10 cycles with n=32 (0x20) -> exactly one operation, f=2178309; start toggled and n changed during OP -> ignored, result unchanged.
- Complete n=10 (f=55), then start n=33 and assert abort on 5th OP cycle -> no done_tick, IDLE next cycle, f stays 55, ovf 0; subsequent n=33 run -> f=3524578.
- Mid-OP rst=1 for 1 cycle during n=37 (0x25) -> next cycle ready=1, f=0, ovf=0, no done_tick; then n=37 -> f=24157817.
- Parameter variant N_W=4, F_W=8: n=13 -> f=233, ovf=0; n=14 -> f=255, ovf=1; n=15 -> f=255, ovf=1.
